// File: rtl/miso_phase_aligner.sv
// Oversampled MISO deserialiser with per-channel cable-delay compensation.
// Latency: word_valid WIN cycles after frame_start; no backpressure (free-running strobe, consumer must keep up).
// Optional DDR capture path is built only when MISO_DDR_EN is defined.
module miso_phase_aligner #(
    parameter int NUM_CH    = 8,
    parameter int WORD_W    = 16,
    parameter int OSR       = 4,
    parameter int MAX_DELAY = 11,
    parameter int DELAY_W   = 4
) (
    input  logic                       dataclk,
    input  logic                       reset_n,
    input  logic                       frame_start,
    input  logic [NUM_CH-1:0]          miso_in,
    input  logic [NUM_CH*DELAY_W-1:0]  delay,
    output logic [NUM_CH*WORD_W-1:0]   word_sdr,
    output logic [NUM_CH*WORD_W-1:0]   word_ddr,
    output logic                       word_valid,
    output logic                       frame_abort,
    output logic [NUM_CH-1:0]          delay_clamped
);

    localparam int WIN   = (WORD_W-1)*OSR + MAX_DELAY + OSR/2 + 1;
    localparam int IDX_W = $clog2(WIN);
    localparam logic [DELAY_W-1:0] MAXD = DELAY_W'(MAX_DELAY);
    localparam logic [IDX_W-1:0]   LAST = IDX_W'(WIN-1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t                           state, state_nxt;
    logic [IDX_W-1:0]                 idx;
    logic [IDX_W-1:0]                 cur_idx;
    logic [NUM_CH-1:0][DELAY_W-1:0]   dly_q, dly_cur;
    logic [NUM_CH-1:0]                clamp_now;
    logic [NUM_CH-1:0]                hit_sdr;
    logic [NUM_CH-1:0][WORD_W-1:0]    sr_sdr, sr_sdr_nxt;
    logic                             capturing, last_tick;

    // The frame_start cycle is already sample 0, so it sees the fresh delays.
    assign capturing = frame_start || (state == CAPTURE);
    assign cur_idx   = frame_start ? '0 : idx;
    assign last_tick = (state == CAPTURE) && (idx == LAST) && !frame_start;

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = CAPTURE;
            CAPTURE: begin
                if (frame_start)       state_nxt = CAPTURE;
                else if (idx == LAST)  state_nxt = DONE;
            end
            DONE:    state_nxt = frame_start ? CAPTURE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        int offs;
        offs       = 0;
        clamp_now  = '0;
        dly_cur    = dly_q;
        hit_sdr    = '0;
        sr_sdr_nxt = sr_sdr;
        for (int c = 0; c < NUM_CH; c++) begin
            clamp_now[c] = delay[c*DELAY_W +: DELAY_W] > MAXD;
            if (frame_start) begin
                dly_cur[c]    = clamp_now[c] ? MAXD : delay[c*DELAY_W +: DELAY_W];
                sr_sdr_nxt[c] = '0;
            end
            offs       = int'(cur_idx) - int'(dly_cur[c]);
            hit_sdr[c] = capturing && (offs >= 0) && (offs % OSR == 0) && (offs < WORD_W*OSR);
            if (hit_sdr[c])
                sr_sdr_nxt[c] = {sr_sdr_nxt[c][WORD_W-2:0], miso_in[c]};
        end
    end

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            idx           <= '0;
            dly_q         <= '0;
            sr_sdr        <= '0;
            word_sdr      <= '0;
            word_valid    <= 1'b0;
            frame_abort   <= 1'b0;
            delay_clamped <= '0;
        end else begin
            word_valid  <= last_tick;
            frame_abort <= frame_start && (state == CAPTURE);
            sr_sdr      <= sr_sdr_nxt;
            if (frame_start) begin
                dly_q         <= dly_cur;
                delay_clamped <= delay_clamped | clamp_now;
                idx           <= IDX_W'(1);
            end else if (state == CAPTURE && idx != LAST) begin
                idx <= idx + 1'b1;
            end
            if (last_tick)
                word_sdr <= sr_sdr_nxt;
        end
    end

`ifdef MISO_DDR_EN
    logic [NUM_CH-1:0][WORD_W-1:0] sr_ddr, sr_ddr_nxt;

    // Second-half-bit samples sit OSR/2 ticks after the SDR sample point.
    always_comb begin
        int offs;
        offs       = 0;
        sr_ddr_nxt = sr_ddr;
        for (int c = 0; c < NUM_CH; c++) begin
            if (frame_start)
                sr_ddr_nxt[c] = '0;
            offs = int'(cur_idx) - int'(dly_cur[c]) - OSR/2;
            if (capturing && (offs >= 0) && (offs % OSR == 0) && (offs < WORD_W*OSR))
                sr_ddr_nxt[c] = {sr_ddr_nxt[c][WORD_W-2:0], miso_in[c]};
        end
    end

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            sr_ddr   <= '0;
            word_ddr <= '0;
        end else begin
            sr_ddr <= sr_ddr_nxt;
            if (last_tick)
                word_ddr <= sr_ddr_nxt;
        end
    end
`else
    assign word_ddr = '0;
`endif

endmodule

// File: tb/tb_miso_phase_aligner.sv
// Bench for miso_phase_aligner: directed frame scenarios plus random frames, checked
// every cycle against a sample-array reference model.
module tb_miso_phase_aligner;
    localparam int NUM_CH    = 8;
    localparam int WORD_W    = 16;
    localparam int OSR       = 4;
    localparam int MAX_DELAY = 11;
    localparam int DELAY_W   = 4;
    localparam int WIN       = (WORD_W-1)*OSR + MAX_DELAY + OSR/2 + 1;
    localparam int BW        = NUM_CH*WORD_W;

    logic                      dataclk;
    logic                      reset_n;
    logic                      frame_start;
    logic [NUM_CH-1:0]         miso_in;
    logic [NUM_CH*DELAY_W-1:0] delay;
    logic [BW-1:0]             word_sdr, word_ddr;
    logic                      word_valid, frame_abort;
    logic [NUM_CH-1:0]         delay_clamped;

    miso_phase_aligner #(
        .NUM_CH(NUM_CH), .WORD_W(WORD_W), .OSR(OSR), .MAX_DELAY(MAX_DELAY), .DELAY_W(DELAY_W)
    ) dut (
        .dataclk(dataclk), .reset_n(reset_n), .frame_start(frame_start),
        .miso_in(miso_in), .delay(delay),
        .word_sdr(word_sdr), .word_ddr(word_ddr), .word_valid(word_valid),
        .frame_abort(frame_abort), .delay_clamped(delay_clamped)
    );

    initial dataclk = 1'b0;
    always #5 dataclk = ~dataclk;

    typedef struct {
        int            at;
        logic [BW-1:0] sdr;
        logic [BW-1:0] ddr;
    } pub_t;

    int                checks = 0;
    int                errors = 0;
    int                cyc    = 0;
    pub_t              pubq[$];
    logic [BW-1:0]     last_sdr, last_ddr;
    logic [NUM_CH-1:0] clamp_m;
    int                abort_at;
    bit                active;
    int                fstart;
    int                dl[NUM_CH];
    logic [NUM_CH-1:0] samp[WIN];
    logic [WORD_W-1:0] wa[NUM_CH], wb[NUM_CH];
    int                sh[NUM_CH];
    logic [NUM_CH*DELAY_W-1:0] dbus;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = 1'b0;
        if (pubq.size() > 0 && pubq[0].at == cyc) begin
            v        = 1'b1;
            last_sdr = pubq[0].sdr;
            last_ddr = pubq[0].ddr;
            void'(pubq.pop_front());
        end
        chk("word_valid",    BW'(word_valid), BW'(v));
        chk("word_sdr",      word_sdr, last_sdr);
        chk("word_ddr",      word_ddr, last_ddr);
        chk("frame_abort",   BW'(frame_abort), BW'(cyc == abort_at));
        chk("delay_clamped", BW'(delay_clamped), BW'(clamp_m));
    endtask

    task automatic tick();
        @(posedge dataclk);
        #1;
        cyc++;
        check_outputs();
    endtask

    // Model: a frame is just the WIN samples after frame_start; bits are picked by index.
    task automatic apply();
        int f;
        pub_t p;
        if (!reset_n) return;
        if (frame_start) begin
            if (active) abort_at = cyc + 1;
            active = 1'b1;
            fstart = cyc;
            for (int c = 0; c < NUM_CH; c++) begin
                f = int'(delay[c*DELAY_W +: DELAY_W]);
                dl[c] = (f > MAX_DELAY) ? MAX_DELAY : f;
                if (f > MAX_DELAY) clamp_m[c] = 1'b1;
            end
        end
        if (active) begin
            samp[cyc-fstart] = miso_in;
            if (cyc - fstart == WIN-1) begin
                p.at  = cyc + 1;
                p.sdr = '0;
                p.ddr = '0;
                for (int c = 0; c < NUM_CH; c++)
                    for (int k = 0; k < WORD_W; k++) begin
                        p.sdr[c*WORD_W + WORD_W-1-k] = samp[dl[c] + k*OSR][c];
`ifdef MISO_DDR_EN
                        p.ddr[c*WORD_W + WORD_W-1-k] = samp[dl[c] + OSR/2 + k*OSR][c];
`endif
                    end
                pubq.push_back(p);
                active = 1'b0;
            end
        end
    endtask

    function automatic logic wave_bit(input int c, input int i);
        int j, k;
        j = i - sh[c];
        if (j < 0 || j >= WORD_W*OSR) return 1'($urandom);
        k = j / OSR;
        return ((j % OSR) >= OSR/2) ? wb[c][WORD_W-1-k] : wa[c][WORD_W-1-k];
    endfunction

    task automatic run(input int n, input bit start);
        for (int i = 0; i < n; i++) begin
            tick();
            frame_start = start && (i == 0);
            delay       = frame_start ? dbus : $urandom;
            for (int c = 0; c < NUM_CH; c++) miso_in[c] = wave_bit(c, i);
            apply();
        end
    endtask

    task automatic set_ch(input int c, input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                          input int shift, input int d);
        wa[c] = a;
        wb[c] = b;
        sh[c] = shift;
        dbus[c*DELAY_W +: DELAY_W] = DELAY_W'(d);
    endtask

    task automatic default_chs();
        logic [WORD_W-1:0] w;
        for (int c = 0; c < NUM_CH; c++) begin
            w = WORD_W'($urandom);
            set_ch(c, w, w, 0, 0);
        end
    endtask

    task automatic do_reset(input int hold);
        reset_n     = 1'b0;
        frame_start = 1'b0;
        #1;
        active   = 1'b0;
        pubq.delete();
        last_sdr = '0;
        last_ddr = '0;
        clamp_m  = '0;
        abort_at = -10;
        check_outputs();
        repeat (hold) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int d;
        logic [WORD_W-1:0] w;
        reset_n     = 1'b0;
        frame_start = 1'b0;
        miso_in     = '0;
        delay       = '0;
        dbus        = '0;
        last_sdr    = '0;
        last_ddr    = '0;
        clamp_m     = '0;
        abort_at    = -10;
        active      = 1'b0;
        fstart      = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            dl[c] = 0; sh[c] = 0; wa[c] = '0; wb[c] = '0;
        end
        repeat (3) tick();
        reset_n = 1'b1;
        run(4, 1'b0);

        // All delays zero, ch0 = 0xA5C3
        default_chs();
        set_ch(0, 16'hA5C3, 16'hA5C3, 0, 0);
        run(WIN+3, 1'b1);
        chk("plan_a5c3", BW'(word_sdr[15:0]), BW'(16'hA5C3));

        // Per-channel delays 0..7
        for (int c = 0; c < NUM_CH; c++) begin
            w = 16'h1234 + WORD_W'(c);
            set_ch(c, w, w, c, c);
        end
        run(WIN+2, 1'b1);
        for (int c = 0; c < NUM_CH; c++)
            chk("plan_delay_word", BW'(word_sdr[c*WORD_W +: WORD_W]), BW'(16'h1234 + c));

        // Over-range delay clamps to MAX_DELAY and sets the sticky flag
        default_chs();
        set_ch(3, 16'hBEEF, 16'hBEEF, MAX_DELAY, 15);
        run(WIN+2, 1'b1);
        chk("plan_clamp_word", BW'(word_sdr[3*WORD_W +: WORD_W]), BW'(16'hBEEF));
        chk("plan_clamp_flag", BW'(delay_clamped[3]), BW'(1'b1));

        // Abort: second frame_start 30 cycles in
        default_chs();
        run(30, 1'b1);
        default_chs();
        run(WIN+3, 1'b1);

        // DDR halves
        default_chs();
        set_ch(0, 16'h00FF, 16'h1234, 0, 0);
        run(WIN+2, 1'b1);
        chk("plan_ddr_sdr", BW'(word_sdr[15:0]), BW'(16'h00FF));
`ifdef MISO_DDR_EN
        chk("plan_ddr_ddr", BW'(word_ddr[15:0]), BW'(16'h1234));
`else
        chk("plan_ddr_off", BW'(word_ddr[15:0]), BW'(16'h0000));
`endif

        // Back-to-back: next frame_start in the strobe cycle
        default_chs();
        run(WIN, 1'b1);
        default_chs();
        run(WIN, 1'b1);
        run(3, 1'b0);

        // Random delays and words
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                d = int'($urandom_range(0, 15));
                set_ch(c, WORD_W'($urandom), WORD_W'($urandom), (d > MAX_DELAY) ? MAX_DELAY : d, d);
            end
            run(WIN + int'($urandom_range(0, 3)), 1'b1);
        end
        run(3, 1'b0);

        // Reset at idx 40 loses the frame; next frame is clean
        default_chs();
        run(41, 1'b1);
        do_reset(3);
        default_chs();
        set_ch(0, 16'h5A3C, 16'h5A3C, 0, 0);
        run(WIN+2, 1'b1);
        chk("plan_after_reset", BW'(word_sdr[15:0]), BW'(16'h5A3C));

        chk("pending_empty", BW'(pubq.size()), BW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
